mdma_c2h_axis_pkt_gen: RTL

MDMA_C2H_AXIS_PKT_GEN -- requirements
Module: mdma_c2h_axis_pkt_gen

---
 rtl/mdma_c2h_pkg.sv | 19 +
 rtl/mdma_c2h_pattern_beat.sv | 40 ++++
 rtl/mdma_c2h_axis_pkt_gen.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mdma_c2h_pkg.sv
// Shared constants and types for the C2H AXI-Stream packet generator.
package mdma_c2h_pkg;

  localparam int BEAT_BYTES = 64;
  localparam int BEAT_SHIFT = 6;
  localparam int WORD_BYTES = 4;
  localparam int MTY_W      = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Empty bytes on the final beat: (64 - len mod 64) mod 64.
  function automatic logic [MTY_W-1:0] last_mty(input logic [MTY_W-1:0] len_lo);
    return -len_lo;
  endfunction

endpackage

// File: rtl/mdma_c2h_pattern_beat.sv
// Builds one payload beat: word w of the packet carries seed+w, and bytes at
// or beyond the packet length are forced to zero.
module mdma_c2h_pattern_beat
  import mdma_c2h_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int LEN_W  = 16,
  parameter int BEAT_W = LEN_W - BEAT_SHIFT + 1
) (
  input  logic [31:0]       seed_i,
  input  logic [BEAT_W-1:0] beat_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [DATA_W-1:0] data_o
);

  localparam int WORDS = DATA_W / (8 * WORD_BYTES);
  localparam int OFF_W = BEAT_W + BEAT_SHIFT;

  logic [OFF_W-1:0] beat_base;
  logic [OFF_W-1:0] len_ext;
  logic [31:0]      word_base;

  assign beat_base = {beat_i, {BEAT_SHIFT{1'b0}}};
  assign len_ext   = OFF_W'(len_i);
  assign word_base = 32'(beat_i) << (BEAT_SHIFT - 2);

  genvar gi, gj;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_word
      logic [31:0] word_val;
      assign word_val = seed_i + word_base + 32'(gi);
      for (gj = 0; gj < WORD_BYTES; gj++) begin : g_byte
        logic [OFF_W-1:0] byte_off;
        assign byte_off = beat_base + OFF_W'(gi * WORD_BYTES + gj);
        assign data_o[gi*32 + gj*8 +: 8] = (byte_off < len_ext) ? word_val[gj*8 +: 8] : 8'h00;
      end
    end
  endgenerate

endmodule

// File: rtl/mdma_c2h_axis_pkt_gen.sv
// C2H stream packet generator: turns {qid, len, seed} commands into AXI-Stream
// beats with a seeded counting payload, supporting zero-bubble back-to-back packets.
module mdma_c2h_axis_pkt_gen
  import mdma_c2h_pkg::*;
#(
  parameter int DATA_W = 512,
  parameter int QID_W  = 12,
  parameter int LEN_W  = 16
) (
  input  logic              user_clk,
  input  logic              user_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [QID_W-1:0]  cmd_qid,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       cmd_seed,
  output logic [DATA_W-1:0] m_axis_c2h_tdata,
  output logic [QID_W-1:0]  m_axis_c2h_ctrl_qid,
  output logic [LEN_W-1:0]  m_axis_c2h_ctrl_len,
  output logic              m_axis_c2h_tlast,
  output logic [MTY_W-1:0]  m_axis_c2h_mty,
  output logic              m_axis_c2h_tvalid,
  input  logic              m_axis_c2h_tready,
  output logic              cmd_err,
  output logic [31:0]       pkt_cnt
);

  // Wide enough to hold 1024 beats for a 65535-byte packet.
  localparam int BEAT_W = LEN_W - BEAT_SHIFT + 1;
  localparam logic [LEN_W:0] ROUND_UP = (LEN_W + 1)'(BEAT_BYTES - 1);

  state_e            state_q, state_d;
  logic [31:0]       seed_q, seed_d;
  logic [QID_W-1:0]  qid_q, qid_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic [MTY_W-1:0]  mty_q, mty_d;
  logic              cmd_err_q, cmd_err_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;

  logic              beat_fire, last_fire, cmd_fire, load_cmd;
  logic [LEN_W:0]    cmd_len_round;
  logic [BEAT_W-1:0] cmd_beats;
  logic [31:0]       pat_seed;
  logic [BEAT_W-1:0] pat_beat, pat_beats;
  logic [LEN_W-1:0]  pat_len;
  logic [DATA_W-1:0] pat_data;
  logic              nxt_last;
  logic [MTY_W-1:0]  nxt_mty;
  logic              start_pkt, go_idle, advance;

  assign cmd_len_round = {1'b0, cmd_len} + ROUND_UP;
  assign cmd_beats     = BEAT_W'(cmd_len_round >> BEAT_SHIFT);

  always_comb begin
    beat_fire = tvalid_q & m_axis_c2h_tready;
    last_fire = beat_fire & tlast_q;
    cmd_ready = (state_q == IDLE) | ((state_q == SEND) & last_fire);
    cmd_fire  = cmd_valid & cmd_ready;
    load_cmd  = cmd_fire & (cmd_len != '0);
  end

  // The next presented beat is either beat 0 of a new command or the successor
  // of the current beat; one pattern generator serves both cases.
  always_comb begin
    pat_seed  = load_cmd ? cmd_seed  : seed_q;
    pat_beat  = load_cmd ? '0        : beat_q + BEAT_W'(1);
    pat_len   = load_cmd ? cmd_len   : len_q;
    pat_beats = load_cmd ? cmd_beats : beats_q;
    nxt_last  = (pat_beat == pat_beats - BEAT_W'(1));
    nxt_mty   = nxt_last ? last_mty(pat_len[MTY_W-1:0]) : '0;
  end

  mdma_c2h_pattern_beat #(
    .DATA_W (DATA_W),
    .LEN_W  (LEN_W),
    .BEAT_W (BEAT_W)
  ) u_pattern (
    .seed_i (pat_seed),
    .beat_i (pat_beat),
    .len_i  (pat_len),
    .data_o (pat_data)
  );

  always_comb begin
    state_d   = state_q;
    seed_d    = seed_q;
    qid_d     = qid_q;
    len_d     = len_q;
    beats_d   = beats_q;
    beat_d    = beat_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    mty_d     = mty_q;
    cmd_err_d = cmd_fire & ~load_cmd;
    pkt_cnt_d = last_fire ? pkt_cnt_q + 32'd1 : pkt_cnt_q;
    start_pkt = 1'b0;
    go_idle   = 1'b0;
    advance   = 1'b0;

    unique case (state_q)
      IDLE: begin
        start_pkt = load_cmd;
      end
      SEND: begin
        if (last_fire) begin
          start_pkt = load_cmd;
          go_idle   = ~load_cmd;
        end else begin
          advance = beat_fire;
        end
      end
    endcase

    if (start_pkt) begin
      state_d  = SEND;
      seed_d   = cmd_seed;
      qid_d    = cmd_qid;
      len_d    = cmd_len;
      beats_d  = cmd_beats;
      beat_d   = '0;
      tdata_d  = pat_data;
      tvalid_d = 1'b1;
      tlast_d  = nxt_last;
      mty_d    = nxt_mty;
    end else if (go_idle) begin
      state_d  = IDLE;
      tvalid_d = 1'b0;
      tlast_d  = 1'b0;
      mty_d    = '0;
    end else if (advance) begin
      beat_d   = pat_beat;
      tdata_d  = pat_data;
      tlast_d  = nxt_last;
      mty_d    = nxt_mty;
    end
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q   <= IDLE;
      seed_q    <= '0;
      qid_q     <= '0;
      len_q     <= '0;
      beats_q   <= '0;
      beat_q    <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      mty_q     <= '0;
      cmd_err_q <= 1'b0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      seed_q    <= seed_d;
      qid_q     <= qid_d;
      len_q     <= len_d;
      beats_q   <= beats_d;
      beat_q    <= beat_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      mty_q     <= mty_d;
      cmd_err_q <= cmd_err_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign m_axis_c2h_tdata    = tdata_q;
  assign m_axis_c2h_ctrl_qid = qid_q;
  assign m_axis_c2h_ctrl_len = len_q;
  assign m_axis_c2h_tlast    = tlast_q;
  assign m_axis_c2h_mty      = mty_q;
  assign m_axis_c2h_tvalid   = tvalid_q;
  assign cmd_err             = cmd_err_q;
  assign pkt_cnt             = pkt_cnt_q;

endmodule
